// File: rtl/bp_gshare_frontend_if.sv
// Fetch / resolve / PHT signal bundle for the gshare front end.
// slave = predictor front end, master = surrounding pipeline and PHT.
interface bp_gshare_frontend_if #(
  parameter int ADDR_W = 8,
  parameter int PC_W   = 32
);
  logic              lk_valid;
  logic [PC_W-1:0]   lk_pc;
  logic              lk_ready;
  logic              pred_valid;
  logic              pred_taken;
  logic              res_valid;
  logic              res_taken;
  logic              res_ready;
  logic              mispredict;
  logic [ADDR_W-1:0] pht_addr;
  logic              pht_request;
  logic              pht_result;
  logic              pht_taken;
  logic              pht_prediction;

  modport slave (
    input  lk_valid, lk_pc, res_valid, res_taken, pht_prediction,
    output lk_ready, pred_valid, pred_taken, res_ready, mispredict,
           pht_addr, pht_request, pht_result, pht_taken
  );

  modport master (
    output lk_valid, lk_pc, res_valid, res_taken, pht_prediction,
    input  lk_ready, pred_valid, pred_taken, res_ready, mispredict,
           pht_addr, pht_request, pht_result, pht_taken
  );
endinterface

// File: rtl/bp_gshare_frontend.sv
// gshare front end: forms PC^GHR index, issues PHT lookups, keeps an in-order
// queue of in-flight branches, sends counter updates at resolve and repairs
// the speculative GHR on mispredict.
// Optional: define BP_STATS_EN for saturating lookup/resolve/mispredict counters.
module bp_gshare_frontend #(
  parameter int ADDR_W = 8,
  parameter int HIST_W = 8,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 8
) (
  input  logic clk,
  input  logic rst_n,
  bp_gshare_frontend_if.slave bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_resolves,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [HIST_W-1:0] r_ghr;
  logic [ADDR_W-1:0] r_q_idx  [DEPTH];
  logic [HIST_W-1:0] r_q_ckpt [DEPTH];
  logic              r_q_pred [DEPTH];
  logic              r_q_known[DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_pending;  // one lookup in flight, answer arrives this cycle

  logic [ADDR_W-1:0] w_idx;
  logic [PTR_W-1:0]  w_last;
  logic w_full, w_empty, w_res_ready, w_res_acc, w_lk_ready, w_lk_acc, w_mis;
  logic w_unused_pc;

  assign w_unused_pc = ^{bus.lk_pc[PC_W-1:ADDR_W+2], bus.lk_pc[1:0]};
  assign w_idx       = bus.lk_pc[ADDR_W+1:2] ^ ADDR_W'(r_ghr);
  assign w_last      = r_tail - PTR_W'(1);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_res_ready = !w_empty && r_q_known[r_head];
  assign w_res_acc   = bus.res_valid && w_res_ready;
  // Resolve owns the shared pht_addr port, so it blocks a lookup that cycle.
  assign w_lk_ready  = !w_full && !r_pending && !w_res_acc;
  assign w_lk_acc    = bus.lk_valid && w_lk_ready;
  assign w_mis       = w_res_acc && (bus.res_taken != r_q_pred[r_head]);

  // Handshake and PHT strobes straight from state plus inputs.
  always_comb begin
    bus.lk_ready    = w_lk_ready;
    bus.res_ready   = w_res_ready;
    bus.mispredict  = w_mis;
    bus.pred_valid  = r_pending && !w_mis;  // answer for a flushed branch is dropped
    bus.pred_taken  = r_pending && !w_mis && bus.pht_prediction;
    bus.pht_request = w_lk_acc;
    bus.pht_result  = w_res_acc;
    bus.pht_taken   = w_res_acc && bus.res_taken;
    bus.pht_addr    = '0;
    if (w_res_acc)     bus.pht_addr = r_q_idx[r_head];
    else if (w_lk_acc) bus.pht_addr = w_idx;
  end

  // Speculative history: shift in predictions, restore checkpoint on mispredict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_ghr <= '0;
    else if (w_mis)     r_ghr <= {r_q_ckpt[r_head][HIST_W-2:0], bus.res_taken};
    else if (r_pending) r_ghr <= {r_ghr[HIST_W-2:0], bus.pht_prediction};
  end

  // In-flight queue: push on lookup, fill tail on return, pop on resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0; r_tail <= '0; r_count <= '0; r_pending <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_idx[i] <= '0; r_q_ckpt[i] <= '0; r_q_pred[i] <= 1'b0; r_q_known[i] <= 1'b0;
      end
    end else if (w_mis) begin
      r_head <= '0; r_tail <= '0; r_count <= '0; r_pending <= 1'b0;
    end else begin
      if (r_pending) begin
        r_q_pred[w_last]  <= bus.pht_prediction;
        r_q_known[w_last] <= 1'b1;
        r_pending         <= 1'b0;
      end
      if (w_res_acc) r_head <= r_head + PTR_W'(1);
      if (w_lk_acc) begin
        r_q_idx[r_tail]   <= w_idx;
        r_q_ckpt[r_tail]  <= r_ghr;
        r_q_pred[r_tail]  <= 1'b0;
        r_q_known[r_tail] <= 1'b0;
        r_tail            <= r_tail + PTR_W'(1);
        r_pending         <= 1'b1;
      end
      r_count <= r_count + CNT_W'(w_lk_acc) - CNT_W'(w_res_acc);
    end
  end

`ifdef BP_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups <= '0; stat_resolves <= '0; stat_mispredicts <= '0;
    end else begin
      if (w_lk_acc  && stat_lookups     != '1) stat_lookups     <= stat_lookups + 32'd1;
      if (w_res_acc && stat_resolves    != '1) stat_resolves    <= stat_resolves + 32'd1;
      if (w_mis     && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bp_gshare_frontend.sv
// Bench for bp_gshare_frontend: queue-based reference model, per-cycle output
// compare, directed scenarios with literal expectations, then random traffic.
module tb_bp_gshare_frontend;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_gshare_frontend_if #(.ADDR_W(8), .PC_W(32)) bus ();

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups, stat_resolves, stat_mispredicts;
  bp_gshare_frontend #(.ADDR_W(8), .HIST_W(8), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .stat_lookups(stat_lookups), .stat_resolves(stat_resolves),
    .stat_mispredicts(stat_mispredicts));
`else
  bp_gshare_frontend #(.ADDR_W(8), .HIST_W(8), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0] q_idx[$];
  bit [7:0] q_ck[$];
  bit       q_pr[$];
  bit       m_pend;
  bit [7:0] m_ghr;

  function automatic bit m_res_ready();
    // head is known unless it is the single entry still awaiting its prediction
    return (q_idx.size() > 0) && !(m_pend && q_idx.size() == 1);
  endfunction

  function automatic bit m_res_acc();
    return bus.res_valid && m_res_ready();
  endfunction

  function automatic bit m_lk_ready();
    return (q_idx.size() < DEPTH) && !m_pend && !m_res_acc();
  endfunction

  function automatic bit m_mis();
    return m_res_acc() && (bus.res_taken != q_pr[0]);
  endfunction

  function automatic bit [7:0] m_index();
    return bus.lk_pc[9:2] ^ m_ghr;
  endfunction

  function automatic logic [15:0] m_expect();
    bit lk_acc, res_acc, mis, pv;
    bit [7:0] addr;
    res_acc = m_res_acc();
    lk_acc  = bus.lk_valid && m_lk_ready();
    mis     = m_mis();
    pv      = m_pend && !mis;
    addr    = res_acc ? q_idx[0] : (lk_acc ? m_index() : 8'h00);
    return {m_lk_ready(), pv, pv & bus.pht_prediction, m_res_ready(), mis,
            lk_acc, res_acc, res_acc & bus.res_taken, addr};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_idx.delete(); q_ck.delete(); q_pr.delete();
      m_pend = 0; m_ghr = 0;
    end else begin
      bit lk_acc, res_acc, mis;
      bit [7:0] idx;
      res_acc = m_res_acc();
      lk_acc  = bus.lk_valid && m_lk_ready();
      mis     = m_mis();
      idx     = m_index();
      if (mis) begin
        m_ghr = {q_ck[0][6:0], bus.res_taken};
        q_idx.delete(); q_ck.delete(); q_pr.delete();
        m_pend = 0;
      end else begin
        if (m_pend) begin
          q_pr[q_pr.size()-1] = bus.pht_prediction;
          m_ghr  = {m_ghr[6:0], bus.pht_prediction};
          m_pend = 0;
        end
        if (res_acc) begin
          void'(q_idx.pop_front()); void'(q_ck.pop_front()); void'(q_pr.pop_front());
        end
        if (lk_acc) begin
          q_idx.push_back(idx); q_ck.push_back(m_ghr); q_pr.push_back(1'b0);
          m_pend = 1;
        end
      end
    end
  end

  // Every cycle: full output bundle against the model, away from the edge.
  always @(negedge clk) begin
    chk("cycle_outputs",
        {16'h0, bus.lk_ready, bus.pred_valid, bus.pred_taken, bus.res_ready,
         bus.mispredict, bus.pht_request, bus.pht_result, bus.pht_taken, bus.pht_addr},
        {16'h0, m_expect()});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit lkv, input logic [31:0] pc, input bit rv,
                     input bit rt, input bit pp);
    @(posedge clk); #1;
    bus.lk_valid = lkv; bus.lk_pc = pc; bus.res_valid = rv;
    bus.res_taken = rt; bus.pht_prediction = pp;
    #2;
  endtask

  task automatic idle_in();
    bus.lk_valid = 0; bus.lk_pc = '0; bus.res_valid = 0;
    bus.res_taken = 0; bus.pht_prediction = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // lookup + return cycle with prediction pp
  task automatic lookup(input logic [31:0] pc, input bit pp);
    cyc(1, pc, 0, 0, 0);
    cyc(0, 0, 0, 0, pp);
  endtask

  initial begin
    idle_in();
    #2;
    chk("reset_lk_ready", {31'h0, bus.lk_ready}, 32'h1);
    chk("reset_others", {23'h0, bus.pred_valid, bus.pred_taken, bus.res_ready,
        bus.mispredict, bus.pht_request, bus.pht_result, bus.pht_taken, bus.pht_addr}, 32'h0);
    do_reset();

    // first lookup: idx 0x10, then return with prediction 1
    cyc(1, 32'h40, 0, 0, 0);
    chk("lk1_addr", {24'h0, bus.pht_addr}, 32'h10);
    chk("lk1_req", {31'h0, bus.pht_request}, 32'h1);
    cyc(1, 32'h40, 0, 0, 1);
    chk("ret1_pred", {30'h0, bus.pred_valid, bus.pred_taken}, 32'h3);
    chk("ret1_bubble", {31'h0, bus.lk_ready}, 32'h0);
    cyc(1, 32'h40, 0, 0, 0);
    chk("lk2_addr_ghr1", {24'h0, bus.pht_addr}, 32'h11);
    cyc(0, 0, 0, 0, 1);
    // correct resolve of head (idx 0x10, pred 1)
    cyc(0, 0, 1, 1, 0);
    chk("res_ok_strobes", {29'h0, bus.pht_result, bus.pht_taken, bus.mispredict}, 32'h6);
    chk("res_ok_addr", {24'h0, bus.pht_addr}, 32'h10);
    cyc(1, 32'h40, 0, 0, 0);
    chk("ghr_unchanged", {24'h0, bus.pht_addr}, 32'h13);
    cyc(0, 0, 0, 0, 0);

    // three taken predictions, head resolves not-taken -> repair to 0
    do_reset();
    repeat (3) lookup(32'h40, 1);
    cyc(0, 0, 1, 0, 0);
    chk("mis_pulse", {31'h0, bus.mispredict}, 32'h1);
    chk("mis_addr", {24'h0, bus.pht_addr}, 32'h10);
    cyc(0, 0, 1, 0, 0);
    chk("flush_res_ready", {30'h0, bus.res_ready, bus.pht_result}, 32'h0);
    cyc(1, 32'h40, 0, 0, 0);
    chk("ghr_repaired", {24'h0, bus.pht_addr}, 32'h10);
    cyc(0, 0, 0, 0, 1);

    // fill to DEPTH, then one resolve frees a slot
    do_reset();
    for (int i = 0; i < DEPTH; i++) lookup(32'h100 + 32'(i * 4), 1);
    cyc(1, 32'h40, 0, 0, 0);
    chk("full_lk_ready", {30'h0, bus.lk_ready, bus.pht_request}, 32'h0);
    cyc(0, 0, 1, 1, 0);
    chk("full_res_acc", {31'h0, bus.pht_result}, 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("after_pop_lk_ready", {31'h0, bus.lk_ready}, 32'h1);

    // reset while a lookup is pending with five entries queued
    do_reset();
    for (int i = 0; i < 4; i++) lookup(32'h200 + 32'(i * 4), 1);
    cyc(1, 32'h40, 0, 0, 0);
    #1;
    idle_in();
    rst_n = 0;
    #1;
    chk("midrst_lk_ready", {31'h0, bus.lk_ready}, 32'h1);
    chk("midrst_others", {23'h0, bus.pred_valid, bus.pred_taken, bus.res_ready,
        bus.mispredict, bus.pht_request, bus.pht_result, bus.pht_taken, bus.pht_addr}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc(0, 0, 1, 1, 1);
    chk("midrst_no_pred", {29'h0, bus.pred_valid, bus.res_ready, bus.pht_result}, 32'h0);

    // random traffic; biased so the queue sometimes fills before a mispredict
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8);
    end

    @(posedge clk); #1 idle_in();
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
